// File: rtl/eta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eta_pkg
//  Description : Shared types and constants for the error-tolerant-adder
//                error monitor (state encoding, default widths, saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
package eta_pkg;

    // Default widths: operand, sample counters, absolute-error accumulator
    localparam int unsigned c_WIDTH = 8;
    localparam int unsigned c_CNT_W = 16;
    localparam int unsigned c_ACC_W = 24;

    // Ceiling of sum_abs_err at the default accumulator width
    localparam logic [c_ACC_W-1:0] c_SUM_SAT = '1;

    // Run-control states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eta_state_t;

endpackage
`default_nettype wire

// File: rtl/eta_abs_diff.sv
`default_nettype none
// ============================================================================
//  Module      : eta_abs_diff
//  Description : Combinational absolute difference |x - y|, always computed
//                as larger minus smaller so the result never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module eta_abs_diff #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_diff
);

    // Subtract the smaller operand from the larger one
    always_comb begin
        o_diff = '0;
        if (i_x >= i_y) begin
            o_diff = i_x - i_y;
        end else begin
            o_diff = i_y - i_x;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eta_error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : eta_error_monitor
//  Description : Grades an approximate adder over a programmed run of samples.
//                Two-stage pipeline: S1 registers exact sum and approx, S2
//                registers |exact - approx|; metrics fold in the S2 beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module eta_error_monitor
    import eta_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = c_CNT_W,
    parameter int ACC_W = c_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH:0]   max_abs_err
);

    localparam logic [ACC_W-1:0] c_SUM_CEIL = '1;

    eta_state_t       r_state;
    eta_state_t       w_next_state;
    logic [CNT_W-1:0] r_n_latched;
    logic [CNT_W-1:0] r_accepted;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_last_beat;

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_exact;
    logic [WIDTH:0]   r_s1_approx;
    logic             r_s2_valid;
    logic [WIDTH:0]   r_s2_diff;
    logic [WIDTH:0]   w_exact;
    logic [WIDTH:0]   w_diff;
    logic [ACC_W:0]   w_sum_wide;

    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_sum_abs_err;
    logic [WIDTH:0]   r_max_abs_err;

    assign w_in_ready  = (r_state == RUN) && (r_accepted < r_n_latched);
    assign w_accept    = in_valid && w_in_ready;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_beat = w_accept && (r_accepted == (r_n_latched - CNT_W'(1)));
    assign w_exact     = {1'b0, in_a} + {1'b0, in_b};
    assign w_sum_wide  = {1'b0, r_sum_abs_err} + (ACC_W + 1)'(r_s2_diff);

    eta_abs_diff #(
        .W (WIDTH + 1)
    ) u_abs_diff (
        .i_x    (r_s1_exact),
        .i_y    (r_s1_approx),
        .o_diff (w_diff)
    );

    // Next-state logic; DRAIN exits on the edge that leaves both stages empty,
    // so DONE is entered together with the final metric update
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (n_samples != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_last_beat) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_accept && !r_s1_valid) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Run length latch and accepted-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_latched <= '0;
            r_accepted  <= '0;
        end else if (w_start_ok) begin
            r_n_latched <= n_samples;
            r_accepted  <= '0;
        end else if (w_accept) begin
            r_accepted  <= r_accepted + CNT_W'(1);
        end
    end

    // Pipeline stages: S1 holds exact/approx, S2 holds the absolute error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_diff   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= in_approx;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_diff <= w_diff;
            end
        end
    end

    // Metric accumulation; a new run clears on the same edge it starts
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sum_abs_err  <= '0;
            r_max_abs_err  <= '0;
        end else if (r_s2_valid) begin
            r_sample_count <= r_sample_count + CNT_W'(1);
            if (r_s2_diff != '0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_sum_abs_err <= w_sum_wide[ACC_W] ? c_SUM_CEIL : w_sum_wide[ACC_W-1:0];
            if (r_s2_diff > r_max_abs_err) begin
                r_max_abs_err <= r_s2_diff;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = (r_state == RUN) || (r_state == DRAIN);
    assign done         = (r_state == DONE);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign sum_abs_err  = r_sum_abs_err;
    assign max_abs_err  = r_max_abs_err;

endmodule
`default_nettype wire

// File: tb/tb_eta_error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eta_error_monitor
//  Description : Scoreboard bench for eta_error_monitor. Expected run results
//                are queued at run start; a monitor pops and compares them
//                whenever a run completes. A second instance with a 9-bit
//                accumulator shares the stimulus to expose saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eta_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_samples;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [8:0]  in_approx;

    logic        in_ready, busy, done;
    logic [15:0] sample_count, err_count;
    logic [23:0] sum_abs_err;
    logic [8:0]  max_abs_err;

    logic        in_ready_s, busy_s, done_s;
    logic [15:0] sample_count_s, err_count_s;
    logic [8:0]  sum_abs_err_s;
    logic [8:0]  max_abs_err_s;

    always #5 clk = ~clk;

    eta_error_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_samples    (n_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_approx    (in_approx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_abs_err  (sum_abs_err),
        .max_abs_err  (max_abs_err)
    );

    eta_error_monitor #(.ACC_W(9)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_samples    (n_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_approx    (in_approx),
        .busy         (busy_s),
        .done         (done_s),
        .sample_count (sample_count_s),
        .err_count    (err_count_s),
        .sum_abs_err  (sum_abs_err_s),
        .max_abs_err  (max_abs_err_s)
    );

    typedef struct {
        int cnt;
        int err;
        int sum;
        int sat;
        int mx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic r_start_q = 1'b0;
    logic r_done_q  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start     = 1'b1;
        n_samples = 16'(n);
        tick();
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
        int w;
        w         = 0;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        in_valid  = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 50) begin
            tick();
            w++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    // Start sampled at the active edge, so a restart from DONE into DONE
    // still counts as a completed run
    always @(posedge clk) r_start_q <= start;

    // Monitor: each completed run pops one expectation and compares
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1 && (!r_done_q || r_start_q)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample_count", 32'(sample_count), e.cnt);
                chk("err_count",    32'(err_count),    e.err);
                chk("sum_abs_err",  32'(sum_abs_err),  e.sum);
                chk("max_abs_err",  32'(max_abs_err),  e.mx);
                chk("sat_sum",      32'(sum_abs_err_s), e.sat);
                chk("sat_max",      32'(max_abs_err_s), e.mx);
                chk("sat_done",     {31'd0, done_s},    32'd1);
            end
        end
        r_done_q <= done;
    end

    initial begin
        int   hs;
        logic rdy [5];
        logic dn  [5];

        rst = 1'b1; start = 1'b0; n_samples = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_count",    32'(sample_count), 32'd0);
        chk("rst_err",      32'(err_count),    32'd0);
        chk("rst_sum",      32'(sum_abs_err),  32'd0);
        chk("rst_max",      32'(max_abs_err),  32'd0);
        chk("rst_sat_sum",  32'(sum_abs_err_s), 32'd0);
        chk("rst_sat_rdy",  {31'd0, in_ready_s | busy_s}, 32'd0);

        // Three-sample run: errors 2, 8, 0
        exp_q.push_back('{cnt: 3, err: 2, sum: 10, sat: 10, mx: 8});
        start_run(3);
        chk("run_busy", {31'd0, busy}, 32'd1);
        send_beat(8'h0F, 8'h01, 9'h00E);
        send_beat(8'h08, 8'h08, 9'h018);
        send_beat(8'h11, 8'h22, 9'h033);
        wait_done();

        // Backpressure: valid held 5 cycles, only 2 beats taken (error 1 each)
        exp_q.push_back('{cnt: 2, err: 2, sum: 2, sat: 2, mx: 1});
        start_run(2);
        hs = 0;
        in_a = 8'h01; in_b = 8'h02; in_approx = 9'h004; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rdy[i] = in_ready;
            dn[i]  = done;
            if (in_ready) hs++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_handshakes",   32'(hs),          32'd2);
        chk("bp_ready_second", {31'd0, rdy[1]},  32'd1);
        chk("bp_ready_falls",  {31'd0, rdy[2]},  32'd0);
        chk("bp_done_early",   {31'd0, dn[3]},   32'd0);
        chk("bp_done_at_2",    {31'd0, dn[4]},   32'd1);

        // Zero-length run restarted from DONE, then a one-beat run
        exp_q.push_back('{cnt: 0, err: 0, sum: 0, sat: 0, mx: 0});
        start_run(0);
        chk("zero_done",  {31'd0, done},     32'd1);
        chk("zero_ready", {31'd0, in_ready}, 32'd0);
        chk("zero_busy",  {31'd0, busy},     32'd0);
        tick();
        exp_q.push_back('{cnt: 1, err: 1, sum: 8, sat: 8, mx: 8});
        start_run(1);
        send_beat(8'h08, 8'h08, 9'h018);
        wait_done();

        // Saturation: 5 x |0x1FE - 0|; 9-bit accumulator pins at 0x1FF
        exp_q.push_back('{cnt: 5, err: 5, sum: 2550, sat: 511, mx: 510});
        start_run(5);
        for (int i = 0; i < 5; i++) send_beat(8'hFF, 8'hFF, 9'h000);
        wait_done();

        // Reset mid-run after 1 of 4 beats
        start_run(4);
        send_beat(8'h0F, 8'h01, 9'h00E);
        tick();
        tick();
        chk("mid_count_pre", 32'(sample_count), 32'd1);
        chk("mid_sum_pre",   32'(sum_abs_err),  32'd2);
        rst = 1'b1;
        tick();
        chk("mid_busy",  {31'd0, busy},     32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_done",  {31'd0, done},     32'd0);
        chk("mid_count", 32'(sample_count), 32'd0);
        chk("mid_err",   32'(err_count),    32'd0);
        chk("mid_sum",   32'(sum_abs_err),  32'd0);
        chk("mid_max",   32'(max_abs_err),  32'd0);
        rst = 1'b0;
        tick();
        exp_q.push_back('{cnt: 1, err: 0, sum: 0, sat: 0, mx: 0});
        start_run(1);
        send_beat(8'h20, 8'h10, 9'h030);
        wait_done();

        repeat (2) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
